// File: rtl/vending_machine.sv
// Nickel/dime vending controller: latches price on the first coin, pulses dispense, then returns change.
// Optional idle refund is enabled by defining VM_TIMEOUT_EN.
module vending_machine #(
  parameter int PRICE_BASE     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] item_number,
  input  logic       nickel_in,
  input  logic       dime_in,
  output logic       nickel_out,
  output logic       dispense
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISP, CHANGE} state_t;

  state_t     state;
  logic [4:0] credit, price, chg;
  logic [1:0] coin;
  logic [4:0] change, eff_price, sum;
  logic       fresh, take, paid;

`ifdef VM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmr;
`endif

  // coin value in nickels is exactly {dime, nickel}: 1, 2 or 3
  assign coin   = {dime_in, nickel_in};
  assign change = credit - price;

  // fresh = the FSM is at IDLE or leaving for IDLE on this edge, so a coin starts a new transaction
  always_comb begin
    fresh     = (state == IDLE) ||
                (state == DISP && change == 5'd0) ||
                (state == CHANGE && chg <= 5'd1);
    take      = (coin != 2'd0) && (fresh || state == COLLECT);
    eff_price = fresh ? 5'(item_number) + 5'(PRICE_BASE) : price;
    sum       = (fresh ? 5'd0 : credit) + 5'(coin);
    paid      = sum >= eff_price;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      credit     <= '0;
      price      <= '0;
      chg        <= '0;
      nickel_out <= 1'b0;
      dispense   <= 1'b0;
`ifdef VM_TIMEOUT_EN
      tmr        <= '0;
`endif
    end else begin
      nickel_out <= 1'b0;
      dispense   <= 1'b0;
      if (take) begin
        price  <= eff_price;
        credit <= sum;
        chg    <= '0;
`ifdef VM_TIMEOUT_EN
        tmr    <= '0;
`endif
        if (paid) begin
          state    <= DISP;
          dispense <= 1'b1;
        end else begin
          state <= COLLECT;
        end
      end else begin
        case (state)
          IDLE: begin
            credit <= '0;
          end
          COLLECT: begin
`ifdef VM_TIMEOUT_EN
            if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
              state      <= CHANGE;
              chg        <= credit;
              credit     <= '0;
              nickel_out <= 1'b1;
              tmr        <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
`endif
          end
          DISP: begin
            if (change != 5'd0) begin
              state      <= CHANGE;
              chg        <= change;
              nickel_out <= 1'b1;
            end else begin
              state <= IDLE;
            end
            credit <= '0;
          end
          CHANGE: begin
            if (chg > 5'd1) begin
              chg        <= chg - 5'd1;
              nickel_out <= 1'b1;
            end else begin
              chg   <= '0;
              state <= IDLE;
            end
            credit <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: table of coin transactions plus reset,
// back-to-back and idle-credit sequences, checked through an expected-pattern queue.
module tb_vending_machine;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] item_number;
  logic       nickel_in, dime_in;
  logic       nickel_out, dispense;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  vending_machine #(.PRICE_BASE(2), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .item_number(item_number),
    .nickel_in(nickel_in), .dime_in(dime_in),
    .nickel_out(nickel_out), .dispense(dispense)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (dispense === 1'b1 && nickel_out === 1'b1) overlap++;

  typedef struct {
    string      name;
    logic [3:0] item;
    logic [3:0] item_after;
    string      coins;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] dm;
    logic [15:0] nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int coin_val(input byte ch);
    case (ch)
      "N": return 1;
      "D": return 2;
      "B": return 3;
      default: return 0;
    endcase
  endfunction

  // pulse patterns relative to the cycle right after the final coin edge
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int   price, sum;
    price = int'(v.item) + 2;
    sum = 0;
    for (int j = 0; j < v.coins.len(); j++) sum += coin_val(v.coins[j]);
    e.name = v.name;
    e.dm = '0;
    e.nm = '0;
    if (sum >= price) begin
      e.dm[0] = 1'b1;
      for (int j = 0; j < sum - price; j++) e.nm[j+1] = 1'b1;
    end
    return e;
  endfunction

  task automatic drive_coin(input byte ch);
    nickel_in = (ch == "N") || (ch == "B");
    dime_in   = (ch == "D") || (ch == "B");
    @(posedge clock); #1;
    nickel_in = 1'b0;
    dime_in   = 1'b0;
  endtask

  task automatic capture(input int n, output logic [15:0] dm, output logic [15:0] nm);
    dm = '0;
    nm = '0;
    for (int k = 0; k < n; k++) begin
      dm[k] = dispense;
      nm[k] = nickel_out;
      @(posedge clock); #1;
    end
  endtask

  task automatic push(input string name, input logic [15:0] dm, input logic [15:0] nm);
    exp_t e;
    e.name = name; e.dm = dm; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] dm, input logic [15:0] nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: empty queue, got dm %h nm %h", dm, nm);
    end else begin
      e = sb.pop_front();
      chk({e.name, " dispense"}, dm, e.dm);
      chk({e.name, " nickel_out"}, nm, e.nm);
    end
  endtask

  task automatic run_txn(input logic [3:0] item, input logic [3:0] item_after, input string coins);
    logic [15:0] dm, nm;
    item_number = item;
    for (int j = 0; j < coins.len(); j++) begin
      if (j == 1) item_number = item_after;
      drive_coin(coins[j]);
    end
    capture(12, dm, nm);
    pop_check(dm, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] dm, nm;
    vecs.push_back('{"i2 NDD change1",   4'd2,  4'd2,  "NDD"});
    vecs.push_back('{"i0 D exact",       4'd0,  4'd0,  "D"});
    vecs.push_back('{"i1 both exact",    4'd1,  4'd1,  "B"});
    vecs.push_back('{"i2 latch vs 15",   4'd2,  4'd15, "NDN"});
    vecs.push_back('{"i0 both change1",  4'd0,  4'd0,  "B"});
    vecs.push_back('{"i1 DD change1",    4'd1,  4'd1,  "DD"});
    vecs.push_back('{"i3 NDD exact",     4'd3,  4'd3,  "NDD"});
    vecs.push_back('{"i0 NB change2",    4'd0,  4'd0,  "NB"});
    vecs.push_back('{"i15 max change2",  4'd15, 4'd15, "DDDDDDDDB"});

    // reset with random inputs
    reset = 1'b1;
    item_number = 4'($urandom);
    nickel_in = 1'($urandom);
    dime_in = 1'($urandom);
    @(posedge clock); #1;
    item_number = 4'($urandom);
    nickel_in = 1'($urandom);
    dime_in = 1'($urandom);
    @(posedge clock); #1;
    chk("reset dispense", 16'(dispense), 16'h0);
    chk("reset nickel_out", 16'(nickel_out), 16'h0);
    reset = 1'b0;
    nickel_in = 1'b0;
    dime_in = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      exp_t e;
      e = model(vecs[i]);
      sb.push_back(e);
      run_txn(vecs[i].item, vecs[i].item_after, vecs[i].coins);
    end

    // reset mid-transaction discards credit and the latched price
    item_number = 4'd3;
    drive_coin("N");
    reset = 1'b1;
    item_number = 4'($urandom);
    nickel_in = 1'($urandom);
    dime_in = 1'($urandom);
    @(posedge clock); #1;
    reset = 1'b0;
    nickel_in = 1'b0;
    dime_in = 1'b0;
    push("mid reset quiet", 16'h0, 16'h0);
    capture(4, dm, nm);
    pop_check(dm, nm);
    item_number = 4'd0;
    drive_coin("N");
    push("after reset first N", 16'h0, 16'h0);
    capture(3, dm, nm);
    pop_check(dm, nm);
    drive_coin("N");
    push("after reset second N", 16'h1, 16'h0);
    capture(8, dm, nm);
    pop_check(dm, nm);

    // coin accepted on the edge returning to IDLE starts the next transaction
    item_number = 4'd0;
    drive_coin("N");
    drive_coin("B");
    push("back-to-back", 16'h0009, 16'h0006);
    dm = '0;
    nm = '0;
    for (int k = 0; k < 8; k++) begin
      dime_in = (k == 2);
      dm[k] = dispense;
      nm[k] = nickel_out;
      @(posedge clock); #1;
    end
    dime_in = 1'b0;
    pop_check(dm, nm);

`ifdef VM_TIMEOUT_EN
    item_number = 4'd5;
    drive_coin("D");
    push("timeout refund", 16'h0, 16'h0300);
    capture(12, dm, nm);
    pop_check(dm, nm);
`else
    item_number = 4'd5;
    drive_coin("D");
    push("credit held", 16'h0, 16'h0);
    capture(12, dm, nm);
    pop_check(dm, nm);
    item_number = 4'd0;
    drive_coin("D");
    drive_coin("D");
    drive_coin("N");
    push("held credit completes", 16'h1, 16'h0);
    capture(8, dm, nm);
    pop_check(dm, nm);
`endif

    chk("dispense/nickel_out overlap", 16'(overlap), 16'h0);
    chk("scoreboard drained", 16'(sb.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
